// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer: FSM states,
// MISR/LFSR polynomials, pattern/response bit mapping, and the MISR step function.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] MISR_POLY   = 8'h1D;

  // x^5 + x^3 + 1: the feedback bit is p[4] ^ p[2], shifted in at the LSB
  localparam int         LFSR_TAP_HI = 4;
  localparam int         LFSR_TAP_LO = 2;

  // Position of each c17 net within pat_out / resp_in
  localparam int PAT_N1   = 4;
  localparam int PAT_N2   = 3;
  localparam int PAT_N3   = 2;
  localparam int PAT_N6   = 1;
  localparam int PAT_N7   = 0;
  localparam int RESP_N22 = 1;
  localparam int RESP_N23 = 0;

  function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [1:0] resp);
    return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {6'b0, resp};
  endfunction

endpackage

// File: rtl/c17_pattern_gen.sv
// 5-bit pattern source for c17: maximal-length LFSR (mode=0) or binary up-counter (mode=1).
// A load takes priority over an advance.
module c17_pattern_gen
  import c17_bist_pkg::*;
#(
  parameter logic [4:0] SEED = 5'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic       mode,
  output logic [4:0] pat
);

  // NOTE: all sequential state uses non-blocking assignments so that every
  // register samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= 5'h00;
    end else if (load) begin
      pat <= mode ? 5'h00 : SEED;
    end else if (advance) begin
      if (mode) pat <= pat + 5'd1;
      else      pat <= {pat[3:0], pat[LFSR_TAP_HI] ^ pat[LFSR_TAP_LO]};
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 netlist: applies NUM_PATTERNS vectors, compacts the
// responses in an 8-bit MISR and counts ones on N22/N23.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 32,
  parameter int unsigned CNT_W        = 16,
  parameter logic [4:0]  LFSR_SEED    = 5'h01,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic [4:0]       pat_out,
  input  logic [1:0]       resp_in,
  output logic             busy,
  output logic             done,
  output logic [7:0]       signature,
  output logic [CNT_W-1:0] ones_n22,
  output logic [CNT_W-1:0] ones_n23,
  output logic             pass
);

  localparam int unsigned          LAST_IDX = (NUM_PATTERNS == 0) ? 0 : NUM_PATTERNS - 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(LAST_IDX);

  if ((NUM_PATTERNS >> CNT_W) != 0) begin : g_cnt_width_err
    $error("c17_bist_ctrl: NUM_PATTERNS does not fit in CNT_W bits");
  end
  if (LFSR_SEED == 5'h00) begin : g_seed_err
    $error("c17_bist_ctrl: LFSR_SEED must be nonzero");
  end

  state_t           state;
  logic [CNT_W-1:0] pat_cnt;
  logic             run_mode;
  logic             launch;
  logic             capture;
  logic             gen_mode;

  assign launch   = start && (state == IDLE || state == DONE);
  assign capture  = (state == CAPTURE);
  // The incoming mode steers the load; the latched copy steers every advance
  assign gen_mode = launch ? mode : run_mode;

  c17_pattern_gen #(
    .SEED    (LFSR_SEED)
  ) u_pattern_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (launch),
    .advance (capture),
    .mode    (gen_mode),
    .pat     (pat_out)
  );

  // Status outputs are registered from the current state, so they trail it by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pat_cnt   <= '0;
      run_mode  <= 1'b0;
      signature <= 8'h00;
      ones_n22  <= '0;
      ones_n23  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      busy <= (state == APPLY) || (state == CAPTURE);
      done <= (state == DONE);
      pass <= (state == DONE) && (signature == GOLDEN_SIG);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            signature <= 8'h00;
            ones_n22  <= '0;
            ones_n23  <= '0;
            pat_cnt   <= '0;
            run_mode  <= mode;
            state     <= (NUM_PATTERNS == 0) ? DONE : APPLY;
          end
        end
        APPLY: state <= CAPTURE;
        CAPTURE: begin
          signature <= misr_step(signature, resp_in);
          ones_n22  <= ones_n22 + CNT_W'(resp_in[RESP_N22]);
          ones_n23  <= ones_n23 + CNT_W'(resp_in[RESP_N23]);
          pat_cnt   <= pat_cnt + 1'b1;
          state     <= (pat_cnt == LAST_CNT) ? DONE : APPLY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl: a behavioural c17 netlist plus a reference
// model of pattern order, MISR compaction and ones counting.
module tb_c17_bist_ctrl;

  localparam int unsigned NP   = 32;
  localparam logic [4:0]  SEED = 5'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start2 = 1'b0, start0 = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  noise = 2'b00;

  logic [4:0]  pat_out, pat2, pat0;
  logic [1:0]  resp_in, resp2, resp0;
  logic        busy, done, pass, busy2, done2, pass2, busy0, done0, pass0;
  logic [7:0]  signature, sig2, sig0;
  logic [15:0] ones_n22, ones_n23, o22_2, o23_2, o22_0, o23_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // c17 gate-level behaviour written directly from the NAND netlist
  function automatic logic [1:0] c17(input logic [4:0] p);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  assign resp_in = c17(pat_out) ^ noise;
  assign resp2   = c17(pat2);
  assign resp0   = c17(pat0);

  c17_bist_ctrl #(.NUM_PATTERNS(NP), .CNT_W(16), .LFSR_SEED(SEED), .GOLDEN_SIG(8'h00)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pat_out(pat_out), .resp_in(resp_in),
    .busy(busy), .done(done), .signature(signature), .ones_n22(ones_n22), .ones_n23(ones_n23),
    .pass(pass));

  c17_bist_ctrl #(.NUM_PATTERNS(2), .CNT_W(16), .LFSR_SEED(SEED), .GOLDEN_SIG(8'h01)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .pat_out(pat2), .resp_in(resp2),
    .busy(busy2), .done(done2), .signature(sig2), .ones_n22(o22_2), .ones_n23(o23_2),
    .pass(pass2));

  c17_bist_ctrl #(.NUM_PATTERNS(0), .CNT_W(16), .LFSR_SEED(SEED), .GOLDEN_SIG(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode), .pat_out(pat0), .resp_in(resp0),
    .busy(busy0), .done(done0), .signature(sig0), .ones_n22(o22_0), .ones_n23(o23_0),
    .pass(pass0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model values computed from the pattern-source and MISR rules with plain arithmetic
  function automatic logic [4:0] next_pat(input logic m, input logic [4:0] p);
    if (m) return 5'((int'(p) + 1) % 32);
    return 5'(((int'(p) * 2) % 32) + (((int'(p) / 16) + (int'(p) / 4)) % 2));
  endfunction

  function automatic logic [7:0] misr_model(input logic [7:0] s, input logic [1:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ 'h1D;
    return 8'(v ^ int'(r));
  endfunction

  int last_o22, last_o23;

  // One full run on the main instance, started from a negedge while IDLE or DONE
  task automatic run(input logic m, input bit use_noise, input bit hold, input bit pulses);
    logic [4:0] mp;
    logic [7:0] ms;
    logic [1:0] r;
    int o22, o23;
    mode = m; start = 1'b1; noise = 2'b00;
    @(posedge clk);
    @(negedge clk);
    if (hold) mode = ~m; else start = 1'b0;
    mp = m ? 5'h00 : SEED; ms = 8'h00; o22 = 0; o23 = 0;
    chk("load_sig", 32'(signature), 32'(ms));
    chk("load_ones", 32'({ones_n22, ones_n23}), 32'h0);
    for (int i = 0; i < int'(NP); i++) begin
      @(posedge clk);
      @(negedge clk);
      start = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pulses) mode = 1'($urandom_range(0, 1));
      noise = use_noise ? 2'($urandom_range(0, 3)) : 2'b00;
      r = c17(mp) ^ noise;
      chk($sformatf("pat_%0d", i), 32'(pat_out), 32'(mp));
      chk("busy_run", 32'({busy, done}), 32'b10);
      if (!m) chk("lfsr_nonzero", 32'(pat_out != 5'h00), 32'h1);
      ms = misr_model(ms, r);
      o22 += int'(r[1]);
      o23 += int'(r[0]);
      mp = next_pat(m, mp);
      @(posedge clk);
      @(negedge clk);
      start = (pulses && i < int'(NP) - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      chk($sformatf("sig_%0d", i), 32'(signature), 32'(ms));
    end
    chk("done_not_early", 32'(done), 32'h0);
    @(posedge clk);
    @(negedge clk);
    noise = 2'b00;
    chk("done", 32'({busy, done}), 32'b01);
    chk("final_sig", 32'(signature), 32'(ms));
    chk("ones_n22", 32'(ones_n22), 32'(o22));
    chk("ones_n23", 32'(ones_n23), 32'(o23));
    chk("pass", 32'(pass), 32'(ms == 8'h00));
    chk("pat_hold", 32'(pat_out), 32'(mp));
    last_o22 = o22;
    last_o23 = o23;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", 32'({pat_out, signature, busy, done, pass}), 32'h0);
    chk("reset_ones", 32'({ones_n22, ones_n23}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-pattern instance: done one cycle after the start edge
    start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    chk("np0_not_yet", 32'(done0), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("np0_done", 32'({done0, busy0, pass0}), 32'b101);
    chk("np0_sig", 32'(sig0), 32'h0);

    // Two-pattern exhaustive instance: done at start+5, signature 01
    mode = 1'b1; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("np2_wait_%0d", c), 32'(done2), 32'h0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("np2_done", 32'({done2, pass2}), 32'b11);
    chk("np2_sig", 32'(sig2), 32'h01);
    chk("np2_ones", 32'({o22_2, o23_2}), 32'h0000_0001);

    // Exhaustive run: measured probability 18/32 on each output
    run(1'b1, 1'b0, 1'b0, 1'b0);
    chk("exh_n22_18", 32'(last_o22), 32'd18);
    chk("exh_n23_18", 32'(last_o23), 32'd18);

    // LFSR run from seed 01, then randomized runs with noisy responses and start pulses
    run(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      run(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);

    // Start held through DONE: restart with identical result
    run(1'b1, 1'b0, 1'b1, 1'b0);
    chk("restart_n22", 32'(ones_n22), 32'd18);

    // Asynchronous reset during CAPTURE of pattern 3
    mode = 1'($urandom_range(0, 1)); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outs", 32'({pat_out, signature, busy, done, pass}), 32'h0);
    chk("midrst_ones", 32'({ones_n22, ones_n23}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_idle", 32'({busy, done}), 32'b00);
    run(1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
